l2_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter sharing one L2_cache port between the instruction-side L1 (port 0) and the data-side L1 (port 1).
- Serialises requests, holds the L2 strobes for the whole transaction and routes the response to the granted requester.
- Adds a transaction watchdog and hit/miss statistics counters.
- Sits between the two L1 controllers and the L2_cache L1-side interface.

---
 rtl/l2_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2_cache port between the instruction-side
// L1 (port 0) and the data-side L1 (port 1), with a watchdog and hit/miss stats.
module l2_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 11,
    parameter int BLOCK_SIZE     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             p0_read,
    input  logic                             p0_write,
    input  logic [ADDR_WIDTH-1:0]            p0_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] p0_data_in,
    output logic                             p0_ready,
    output logic                             p0_hit,
    output logic                             p0_block_valid,
    output logic                             p0_error,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] p0_data_out,
    input  logic                             p1_read,
    input  logic                             p1_write,
    input  logic [ADDR_WIDTH-1:0]            p1_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] p1_data_in,
    output logic                             p1_ready,
    output logic                             p1_hit,
    output logic                             p1_block_valid,
    output logic                             p1_error,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] p1_data_out,
    output logic [ADDR_WIDTH-1:0]            l2_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_in,
    output logic                             l2_read,
    output logic                             l2_write,
    input  logic                             l2_ready,
    input  logic                             l2_hit,
    input  logic                             l2_block_valid,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out,
    output logic                             busy,
    output logic                             grant_id,
    output logic [CNT_WIDTH-1:0]             hit_count,
    output logic [CNT_WIDTH-1:0]             miss_count
);

    localparam int BLK_W = BLOCK_SIZE * DATA_WIDTH;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                rr_ptr;
    logic                op_rd;
    logic                op_wr;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [BLK_W-1:0]    cap_data;
    logic [WD_W-1:0]     wdog;

    logic p0_req;
    logic p1_req;
    logic grant_sel;
    logic timeout;
    logic done_ok;
    logic done_to;

    assign p0_req  = p0_read | p0_write;
    assign p1_req  = p1_read | p1_write;
    assign timeout = (wdog == WD_LAST);
    assign done_ok = (state == BUSY) && l2_ready;
    assign done_to = (state == BUSY) && !l2_ready && timeout;

    assign l2_addr    = cap_addr;
    assign l2_data_in = cap_data;

    always_comb begin
        if (p0_req && p1_req) grant_sel = rr_ptr;
        else                  grant_sel = p1_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (p0_req || p1_req) state_next = BUSY;
            BUSY:    if (l2_ready || timeout) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes drop in the l2_ready cycle so L2 never re-samples a finished request.
    always_comb begin
        busy     = (state != IDLE);
        l2_read  = (state == BUSY) && op_rd && !l2_ready;
        l2_write = (state == BUSY) && op_wr && !l2_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_rd    <= 1'b0;
            op_wr    <= 1'b0;
            cap_addr <= '0;
            cap_data <= '0;
            grant_id <= 1'b0;
            rr_ptr   <= 1'b0;
            wdog     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        grant_id <= grant_sel;
                        op_wr    <= grant_sel ? p1_write : p0_write;
                        op_rd    <= grant_sel ? (p1_read & ~p1_write) : (p0_read & ~p0_write);
                        cap_addr <= grant_sel ? p1_addr : p0_addr;
                        cap_data <= grant_sel ? p1_data_in : p0_data_in;
                        wdog     <= '0;
                    end
                end
                BUSY: begin
                    wdog <= wdog + 1'b1;
                    if (l2_ready || timeout) rr_ptr <= ~grant_id;
                end
                default: ;
            endcase
        end
    end

    // A timeout pulses ready with error but leaves the previous block in data_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_ready       <= 1'b0;
            p0_hit         <= 1'b0;
            p0_block_valid <= 1'b0;
            p0_error       <= 1'b0;
            p0_data_out    <= '0;
            p1_ready       <= 1'b0;
            p1_hit         <= 1'b0;
            p1_block_valid <= 1'b0;
            p1_error       <= 1'b0;
            p1_data_out    <= '0;
        end else begin
            p0_ready       <= 1'b0;
            p0_hit         <= 1'b0;
            p0_block_valid <= 1'b0;
            p0_error       <= 1'b0;
            p1_ready       <= 1'b0;
            p1_hit         <= 1'b0;
            p1_block_valid <= 1'b0;
            p1_error       <= 1'b0;
            if (done_ok || done_to) begin
                if (grant_id == 1'b0) begin
                    p0_ready       <= 1'b1;
                    p0_hit         <= done_ok & l2_hit;
                    p0_block_valid <= done_ok & l2_block_valid;
                    p0_error       <= done_to;
                    if (done_ok) p0_data_out <= l2_data_out;
                end else begin
                    p1_ready       <= 1'b1;
                    p1_hit         <= done_ok & l2_hit;
                    p1_block_valid <= done_ok & l2_block_valid;
                    p1_error       <= done_to;
                    if (done_ok) p1_data_out <= l2_data_out;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (done_ok) begin
            if (l2_hit) begin
                if (hit_count != {CNT_WIDTH{1'b1}}) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != {CNT_WIDTH{1'b1}}) miss_count <= miss_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: a behavioural L2 model answers the main
// instance; a second instance with a short watchdog covers the timeout path.
module tb_l2_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int BS = 32;
    localparam int BW = DW * BS;
    localparam int CW = 16;

    typedef struct {
        logic          port;
        logic          hit;
        logic          bv;
        logic          err;
        logic [BW-1:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          p0_read, p0_write, p1_read, p1_write;
    logic [AW-1:0] p0_addr, p1_addr, l2_addr;
    logic [BW-1:0] p0_data_in, p1_data_in, p0_data_out, p1_data_out, l2_data_in, l2_data_out;
    logic          p0_ready, p0_hit, p0_block_valid, p0_error;
    logic          p1_ready, p1_hit, p1_block_valid, p1_error;
    logic          l2_read, l2_write, l2_ready, l2_hit, l2_block_valid, busy, grant_id;
    logic [CW-1:0] hit_count, miss_count;

    logic          t_p0_read, t_p0_write, t_p1_read, t_p1_write;
    logic [AW-1:0] t_p0_addr, t_p1_addr, t_l2_addr;
    logic [BW-1:0] t_p0_data_in, t_p1_data_in, t_p0_data_out, t_p1_data_out, t_l2_data_in, t_l2_data_out;
    logic          t_p0_ready, t_p0_hit, t_p0_block_valid, t_p0_error;
    logic          t_p1_ready, t_p1_hit, t_p1_block_valid, t_p1_error;
    logic          t_l2_read, t_l2_write, t_l2_ready, t_l2_hit, t_l2_block_valid, t_busy, t_grant_id;
    logic [CW-1:0] t_hit_count, t_miss_count;

    l2_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS),
                      .TIMEOUT_CYCLES(1024), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_data_in(p0_data_in),
        .p0_ready(p0_ready), .p0_hit(p0_hit), .p0_block_valid(p0_block_valid),
        .p0_error(p0_error), .p0_data_out(p0_data_out),
        .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_data_in(p1_data_in),
        .p1_ready(p1_ready), .p1_hit(p1_hit), .p1_block_valid(p1_block_valid),
        .p1_error(p1_error), .p1_data_out(p1_data_out),
        .l2_addr(l2_addr), .l2_data_in(l2_data_in), .l2_read(l2_read), .l2_write(l2_write),
        .l2_ready(l2_ready), .l2_hit(l2_hit), .l2_block_valid(l2_block_valid),
        .l2_data_out(l2_data_out), .busy(busy), .grant_id(grant_id),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    l2_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS),
                      .TIMEOUT_CYCLES(4), .CNT_WIDTH(CW)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .p0_read(t_p0_read), .p0_write(t_p0_write), .p0_addr(t_p0_addr), .p0_data_in(t_p0_data_in),
        .p0_ready(t_p0_ready), .p0_hit(t_p0_hit), .p0_block_valid(t_p0_block_valid),
        .p0_error(t_p0_error), .p0_data_out(t_p0_data_out),
        .p1_read(t_p1_read), .p1_write(t_p1_write), .p1_addr(t_p1_addr), .p1_data_in(t_p1_data_in),
        .p1_ready(t_p1_ready), .p1_hit(t_p1_hit), .p1_block_valid(t_p1_block_valid),
        .p1_error(t_p1_error), .p1_data_out(t_p1_data_out),
        .l2_addr(t_l2_addr), .l2_data_in(t_l2_data_in), .l2_read(t_l2_read), .l2_write(t_l2_write),
        .l2_ready(t_l2_ready), .l2_hit(t_l2_hit), .l2_block_valid(t_l2_block_valid),
        .l2_data_out(t_l2_data_out), .busy(t_busy), .grant_id(t_grant_id),
        .hit_count(t_hit_count), .miss_count(t_miss_count)
    );

    int            checks = 0;
    int            fails  = 0;
    int            exp_hits;
    int            exp_misses;
    logic [BW-1:0] exp_p0_data;
    logic [BW-1:0] exp_p1_data;
    exp_t          sb[$];

    int model_delay = 2;
    bit model_hit   = 1'b1;
    bit model_never = 1'b0;
    int mcnt        = 0;

    function automatic logic [BW-1:0] model_block(input logic [AW-1:0] a);
        logic [BW-1:0] b;
        for (int w = 0; w < BS; w++) b[w*DW +: DW] = 32'hC0DE_0000 | (32'(a) << 5) | 32'(w);
        return b;
    endfunction

    function automatic logic [BW-1:0] write_block(input logic [7:0] seed);
        logic [BW-1:0] b;
        for (int w = 0; w < BS; w++) b[w*DW +: DW] = 32'h5A00_0000 | (32'(seed) << 8) | 32'(w);
        return b;
    endfunction

    // L2 model: ready arrives model_delay strobe cycles after the request appears.
    initial begin
        l2_ready = 1'b0; l2_hit = 1'b0; l2_block_valid = 1'b0; l2_data_out = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                mcnt = 0; l2_ready = 1'b0;
            end else if (l2_ready) begin
                l2_ready = 1'b0; l2_hit = 1'b0; l2_block_valid = 1'b0; mcnt = 0;
            end else if (l2_read || l2_write) begin
                mcnt++;
                if (!model_never && mcnt == model_delay + 1) begin
                    l2_ready       = 1'b1;
                    l2_hit         = model_hit;
                    l2_block_valid = model_hit;
                    l2_data_out    = model_hit ? model_block(l2_addr) : '0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got no finish, required finish");
        $fatal(1, "[TB] simulation stopped by time limit");
    end

    task automatic wait_ready(input int budget, output bit ok, output logic port, output logic hit,
                              output logic bv, output logic err, output logic [BW-1:0] data);
        ok = 1'b0; port = 1'b0; hit = 1'b0; bv = 1'b0; err = 1'b0; data = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (p0_ready || p1_ready) begin
                ok   = 1'b1;
                port = p1_ready;
                hit  = p1_ready ? p1_hit : p0_hit;
                bv   = p1_ready ? p1_block_valid : p0_block_valid;
                err  = p1_ready ? p1_error : p0_error;
                data = p1_ready ? p1_data_out : p0_data_out;
                return;
            end
        end
    endtask

    task automatic test_reset;
        exp_t e; bit ok; logic port, hit, bv, err; logic [BW-1:0] data;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({p0_ready, p0_hit, p0_block_valid, p0_error, p1_ready, p1_hit, p1_block_valid, p1_error,
             l2_read, l2_write, busy, grant_id} !== 12'b0) begin
            fails++; $display("[TB] FAIL reset_flags: got %b required 0", {p0_ready, p1_ready, l2_read, l2_write, busy, grant_id});
        end
        checks++;
        if ({hit_count, miss_count, l2_addr} !== '0 || {p0_data_out, p1_data_out} !== '0) begin
            fails++; $display("[TB] FAIL reset_regs: got hits %0d misses %0d addr %h, required 0", hit_count, miss_count, l2_addr);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        model_never = 1'b1;
        p0_read = 1'b1; p0_addr = 11'h123;
        repeat (3) @(negedge clk);
        checks++;
        if (l2_read !== 1'b1) begin fails++; $display("[TB] FAIL reset_pre_busy: got l2_read %b required 1", l2_read); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({l2_read, l2_write, busy, grant_id, p0_ready, p1_ready} !== 6'b0 || l2_addr !== '0 || hit_count !== '0) begin
            fails++; $display("[TB] FAIL reset_mid_busy: got rd %b wr %b busy %b addr %h, required 0", l2_read, l2_write, busy, l2_addr);
        end
        @(negedge clk);
        rst_n = 1'b1; model_never = 1'b0; model_delay = 2; model_hit = 1'b1;
        sb.push_back('{port: 1'b0, hit: 1'b1, bv: 1'b1, err: 1'b0, data: model_block(11'h123)});
        exp_hits++;
        @(negedge clk);
        checks++;
        if ({busy, l2_read, grant_id} !== 3'b110) begin
            fails++; $display("[TB] FAIL reset_regrant: got busy/rd/gnt %b required 110", {busy, l2_read, grant_id});
        end
        wait_ready(20, ok, port, hit, bv, err, data);
        checks++;
        if (!ok || sb.size() == 0) begin
            fails++; $display("[TB] FAIL reset_regrant_resp: got no ready, required ready");
        end else begin
            e = sb.pop_front();
            if ({port, hit, bv, err} !== {e.port, e.hit, e.bv, e.err} || data !== e.data) begin
                fails++; $display("[TB] FAIL reset_regrant_resp: got %b/%h required %b/%h", {port, hit, bv, err}, data[31:0], {e.port, e.hit, e.bv, e.err}, e.data[31:0]);
            end
            exp_p0_data = e.data;
        end
        @(posedge clk); #1; p0_read = 1'b0;
    endtask

    task automatic test_hit_latency;
        exp_t e;
        @(posedge clk); #1;
        model_hit = 1'b1; model_delay = 2;
        p0_read = 1'b1; p0_addr = 11'h040;
        sb.push_back('{port: 1'b0, hit: 1'b1, bv: 1'b1, err: 1'b0, data: model_block(11'h040)});
        exp_hits++;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            case (k)
                0: begin
                    checks++;
                    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL lat_t0_idle: got busy %b required 0", busy); end
                end
                1: begin
                    checks++;
                    if ({busy, l2_read, grant_id} !== 3'b110) begin
                        fails++; $display("[TB] FAIL lat_t1_strobe: got busy/rd/gnt %b required 110", {busy, l2_read, grant_id});
                    end
                end
                3: begin
                    checks++;
                    if ({l2_ready, l2_read, busy, p0_ready} !== 4'b1010) begin
                        fails++; $display("[TB] FAIL lat_t3_strobe_drop: got rdy/rd/busy/p0rdy %b required 1010", {l2_ready, l2_read, busy, p0_ready});
                    end
                end
                4: begin
                    checks++;
                    if (p0_ready !== 1'b1 || sb.size() == 0) begin
                        fails++; $display("[TB] FAIL lat_t4_ready: got p0_ready %b required 1", p0_ready);
                    end else begin
                        e = sb.pop_front();
                        checks++;
                        if ({p0_hit, p0_block_valid, p0_error} !== {e.hit, e.bv, e.err} || p0_data_out !== e.data) begin
                            fails++; $display("[TB] FAIL lat_t4_resp: got %b/%h required %b/%h", {p0_hit, p0_block_valid, p0_error}, p0_data_out[31:0], {e.hit, e.bv, e.err}, e.data[31:0]);
                        end
                        exp_p0_data = e.data;
                    end
                    checks++;
                    if (p1_ready !== 1'b0 || p1_data_out !== exp_p1_data) begin
                        fails++; $display("[TB] FAIL lat_p1_undisturbed: got ready %b data %h required 0/%h", p1_ready, p1_data_out[31:0], exp_p1_data[31:0]);
                    end
                end
                5: begin
                    checks++;
                    if ({busy, p0_ready, l2_read} !== 3'b000) begin
                        fails++; $display("[TB] FAIL lat_t5_idle: got busy/rdy/rd %b required 000", {busy, p0_ready, l2_read});
                    end
                end
                default: ;
            endcase
            @(posedge clk); #1;
            if (k == 4) p0_read = 1'b0;
        end
        checks++;
        if (hit_count !== CW'(exp_hits)) begin
            fails++; $display("[TB] FAIL lat_hit_count: got %0d required %0d", hit_count, exp_hits);
        end
    endtask

    task automatic test_round_robin;
        exp_t e; bit ok; logic port, hit, bv, err; logic [BW-1:0] data;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete(); exp_hits = 0; exp_misses = 0; exp_p0_data = '0; exp_p1_data = '0;
        model_hit = 1'b1; model_delay = 2;
        @(posedge clk); #1;
        // Phase 0: both from reset (p0 first); phase 1: p0 alone; phase 2: both (p1 first).
        for (int ph = 0; ph < 3; ph++) begin
            logic first;
            int   n;
            first   = (ph == 2);
            n       = (ph == 1) ? 1 : 2;
            p0_addr = 11'h100 + 11'(ph * 8);
            p1_addr = 11'h300 + 11'(ph * 8);
            p0_read = 1'b1;
            p1_read = (n == 2);
            for (int j = 0; j < n; j++) begin
                logic pj;
                pj = (j == 0) ? first : ~first;
                sb.push_back('{port: pj, hit: 1'b1, bv: 1'b1, err: 1'b0, data: model_block(pj ? p1_addr : p0_addr)});
                exp_hits++;
            end
            for (int j = 0; j < n; j++) begin
                wait_ready(30, ok, port, hit, bv, err, data);
                checks++;
                if (!ok || sb.size() == 0) begin
                    fails++; $display("[TB] FAIL rr_resp ph%0d: got no ready, required ready", ph);
                end else begin
                    e = sb.pop_front();
                    if ({port, hit, bv, err} !== {e.port, e.hit, e.bv, e.err}) begin
                        fails++; $display("[TB] FAIL rr_order ph%0d: got port/flags %b required %b", ph, {port, hit, bv, err}, {e.port, e.hit, e.bv, e.err});
                    end
                    checks++;
                    if (data !== e.data) begin
                        fails++; $display("[TB] FAIL rr_data ph%0d: got %h required %h", ph, data[31:0], e.data[31:0]);
                    end
                    checks++;
                    if ((e.port ? p0_data_out : p1_data_out) !== (e.port ? exp_p0_data : exp_p1_data)) begin
                        fails++; $display("[TB] FAIL rr_other_undisturbed ph%0d: got %h required %h", ph, (e.port ? p0_data_out[31:0] : p1_data_out[31:0]), (e.port ? exp_p0_data[31:0] : exp_p1_data[31:0]));
                    end
                    if (e.port) exp_p1_data = e.data;
                    else        exp_p0_data = e.data;
                end
                @(posedge clk); #1;
                if (port) p1_read = 1'b0;
                else      p0_read = 1'b0;
                if (j + 1 < n) begin
                    @(negedge clk);
                    @(negedge clk);
                    checks++;
                    if ({busy, grant_id} !== {1'b1, ~first}) begin
                        fails++; $display("[TB] FAIL rr_regrant ph%0d: got busy/gnt %b required %b", ph, {busy, grant_id}, {1'b1, ~first});
                    end
                end
            end
        end
        checks++;
        if (hit_count !== CW'(exp_hits) || miss_count !== '0) begin
            fails++; $display("[TB] FAIL rr_counts: got hits %0d misses %0d required %0d/0", hit_count, miss_count, exp_hits);
        end
    endtask

    task automatic test_write_miss;
        exp_t e; int wcyc; bit data_bad; bit read_seen; bit got;
        @(posedge clk); #1;
        model_hit = 1'b0; model_delay = 10;
        wcyc = 0; data_bad = 1'b0; read_seen = 1'b0; got = 1'b0;
        p1_write = 1'b1; p1_read = 1'b1; p1_addr = 11'h7E0; p1_data_in = write_block(8'h3C);
        sb.push_back('{port: 1'b1, hit: 1'b0, bv: 1'b0, err: 1'b0, data: '0});
        exp_misses++;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (l2_write) begin
                wcyc++;
                if (l2_data_in !== p1_data_in || l2_addr !== 11'h7E0) data_bad = 1'b1;
            end
            if (l2_read) read_seen = 1'b1;
            got = p1_ready;
        end
        checks++;
        if (wcyc != 10) begin fails++; $display("[TB] FAIL wr_strobe_len: got %0d cycles required 10", wcyc); end
        checks++;
        if (data_bad || read_seen) begin
            fails++; $display("[TB] FAIL wr_bus: got data_bad %b read_seen %b required 0/0", data_bad, read_seen);
        end
        checks++;
        if (!got || sb.size() == 0) begin
            fails++; $display("[TB] FAIL wr_resp: got no ready, required ready");
        end else begin
            e = sb.pop_front();
            if ({p1_hit, p1_block_valid, p1_error} !== {e.hit, e.bv, e.err} || p1_data_out !== e.data || p0_ready !== 1'b0) begin
                fails++; $display("[TB] FAIL wr_resp: got %b/%h p0rdy %b required %b/%h", {p1_hit, p1_block_valid, p1_error}, p1_data_out[31:0], p0_ready, {e.hit, e.bv, e.err}, e.data[31:0]);
            end
            exp_p1_data = e.data;
        end
        checks++;
        if (miss_count !== CW'(exp_misses) || hit_count !== CW'(exp_hits) || p0_data_out !== exp_p0_data) begin
            fails++; $display("[TB] FAIL wr_counts: got hits %0d misses %0d required %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
        end
        @(posedge clk); #1;
        p1_write = 1'b0; p1_read = 1'b0;
    endtask

    task automatic test_timeout;
        exp_t e; int rcyc; bit got; bit side_bad;
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk); #1;
            rcyc = 0; got = 1'b0; side_bad = 1'b0;
            t_p0_read = 1'b1;
            t_p0_addr = (pass == 0) ? 11'h055 : 11'h066;
            if (pass == 0) sb.push_back('{port: 1'b0, hit: 1'b0, bv: 1'b0, err: 1'b1, data: '0});
            else           sb.push_back('{port: 1'b0, hit: 1'b1, bv: 1'b1, err: 1'b0, data: model_block(11'h066)});
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = t_p0_ready;
                if (t_l2_read) rcyc++;
                if (t_l2_write || t_p1_ready || t_grant_id) side_bad = 1'b1;
                if (t_l2_ready) begin
                    t_l2_ready = 1'b0; t_l2_hit = 1'b0; t_l2_block_valid = 1'b0;
                end else if (pass == 1 && t_l2_read) begin
                    t_l2_ready = 1'b1; t_l2_hit = 1'b1; t_l2_block_valid = 1'b1;
                    t_l2_data_out = model_block(t_l2_addr);
                end
            end
            checks++;
            if (!got || sb.size() == 0) begin
                fails++; $display("[TB] FAIL to_resp pass%0d: got no ready, required ready", pass);
            end else begin
                e = sb.pop_front();
                if ({t_p0_hit, t_p0_block_valid, t_p0_error, t_busy} !== {e.hit, e.bv, e.err, 1'b1} || t_p0_data_out !== e.data) begin
                    fails++; $display("[TB] FAIL to_resp pass%0d: got %b/%h required %b/%h", pass, {t_p0_hit, t_p0_block_valid, t_p0_error, t_busy}, t_p0_data_out[31:0], {e.hit, e.bv, e.err, 1'b1}, e.data[31:0]);
                end
            end
            checks++;
            if (rcyc != ((pass == 0) ? 4 : 1) || side_bad) begin
                fails++; $display("[TB] FAIL to_strobe pass%0d: got %0d read cycles side_bad %b required %0d/0", pass, rcyc, side_bad, (pass == 0) ? 4 : 1);
            end
            checks++;
            if (t_miss_count !== '0 || t_hit_count !== CW'(pass) || t_p1_data_out !== '0 || t_l2_data_in !== '0) begin
                fails++; $display("[TB] FAIL to_counts pass%0d: got hits %0d misses %0d required %0d/0", pass, t_hit_count, t_miss_count, pass);
            end
            @(posedge clk); #1;
            t_p0_read = 1'b0;
        end
    endtask

    initial begin
        p0_read = 1'b0; p0_write = 1'b0; p0_addr = '0; p0_data_in = write_block(8'h11);
        p1_read = 1'b0; p1_write = 1'b0; p1_addr = '0; p1_data_in = write_block(8'h22);
        t_p0_read = 1'b0; t_p0_write = 1'b0; t_p0_addr = '0; t_p0_data_in = '0;
        t_p1_read = 1'b0; t_p1_write = 1'b0; t_p1_addr = '0; t_p1_data_in = '0;
        t_l2_ready = 1'b0; t_l2_hit = 1'b0; t_l2_block_valid = 1'b0; t_l2_data_out = '0;
        exp_hits = 0; exp_misses = 0; exp_p0_data = '0; exp_p1_data = '0;
        test_reset();
        test_hit_latency();
        test_round_robin();
        test_write_miss();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
